// File: rtl/decoder_6b5b.sv
// rtl/decoder_6b5b.sv - 6b/5b sub-block decoder with running disparity; error counter under DECODER_6B5B_ERR_CNT_EN
module decoder_6b5b #(
    parameter logic RD_INIT = 1'b0,
    parameter int   CNT_W   = 8
) (
    input  logic             SBYTECLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    input  logic             i,
    input  logic             RD_LOAD,
    input  logic             RD_VALUE,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    output logic             E,
    output logic             K28,
    output logic             OUT_VALID,
    output logic             CODE_ERR,
    output logic             DISP_ERR,
    output logic             RD_OUT,
    output logic [CNT_W-1:0] ERR_CNT
);

    logic [5:0] s1_code;
    logic       s1_valid;
    logic       rd;

    logic       rd_cur;
    logic [2:0] n1;
    logic [4:0] dec_data;
    logic       dec_hit;
    logic       dec_k;
    logic       disp_err_c;
    logic       rd_next;

    always_ff @(posedge SBYTECLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_code  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_code  <= {a, b, c, d, e, i};
            s1_valid <= IN_VALID;
        end
    end

    always_comb begin
        dec_hit  = 1'b1;
        dec_k    = 1'b0;
        dec_data = 5'd0;
        case (s1_code)
            6'b100111, 6'b011000: dec_data = 5'd0;
            6'b011101, 6'b100010: dec_data = 5'd1;
            6'b101101, 6'b010010: dec_data = 5'd2;
            6'b110001:            dec_data = 5'd3;
            6'b110101, 6'b001010: dec_data = 5'd4;
            6'b101001:            dec_data = 5'd5;
            6'b011001:            dec_data = 5'd6;
            6'b111000, 6'b000111: dec_data = 5'd7;
            6'b111001, 6'b000110: dec_data = 5'd8;
            6'b100101:            dec_data = 5'd9;
            6'b010101:            dec_data = 5'd10;
            6'b110100:            dec_data = 5'd11;
            6'b001101:            dec_data = 5'd12;
            6'b101100:            dec_data = 5'd13;
            6'b011100:            dec_data = 5'd14;
            6'b010111, 6'b101000: dec_data = 5'd15;
            6'b011011, 6'b100100: dec_data = 5'd16;
            6'b100011:            dec_data = 5'd17;
            6'b010011:            dec_data = 5'd18;
            6'b110010:            dec_data = 5'd19;
            6'b001011:            dec_data = 5'd20;
            6'b101010:            dec_data = 5'd21;
            6'b011010:            dec_data = 5'd22;
            6'b111010, 6'b000101: dec_data = 5'd23;
            6'b110011, 6'b001100: dec_data = 5'd24;
            6'b100110:            dec_data = 5'd25;
            6'b010110:            dec_data = 5'd26;
            6'b110110, 6'b001001: dec_data = 5'd27;
            6'b001110:            dec_data = 5'd28;
            6'b101110, 6'b010001: dec_data = 5'd29;
            6'b011110, 6'b100001: dec_data = 5'd30;
            6'b101011, 6'b010100: dec_data = 5'd31;
            6'b001111, 6'b110000: begin
                dec_data = 5'd28;
                dec_k    = 1'b1;
            end
            default:              dec_hit  = 1'b0;
        endcase
    end

    // A load arriving with a code in stage 2 supplies the RD that code is checked against.
    always_comb begin
        rd_cur     = RD_LOAD ? RD_VALUE : rd;
        n1         = 3'($countones(s1_code));
        disp_err_c = ((n1 == 3'd4) &&  rd_cur) ||
                     ((n1 == 3'd2) && !rd_cur) ||
                     ((s1_code == 6'b111000) &&  rd_cur) ||
                     ((s1_code == 6'b000111) && !rd_cur);
        if (n1 > 3'd3)
            rd_next = 1'b1;
        else if (n1 < 3'd3)
            rd_next = 1'b0;
        else
            rd_next = rd_cur;
    end

    always_ff @(posedge SBYTECLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd              <= RD_INIT;
            RD_OUT          <= 1'b0;
            {E, D, C, B, A} <= 5'd0;
            K28             <= 1'b0;
            OUT_VALID       <= 1'b0;
            CODE_ERR        <= 1'b0;
            DISP_ERR        <= 1'b0;
        end else begin
            OUT_VALID <= s1_valid;
            K28       <= s1_valid & dec_k;
            CODE_ERR  <= s1_valid & ~dec_hit;
            DISP_ERR  <= s1_valid & disp_err_c;
            if (s1_valid) begin
                {E, D, C, B, A} <= dec_data;
                rd              <= rd_next;
                RD_OUT          <= rd_next;
            end else begin
                rd <= rd_cur;
                if (RD_LOAD)
                    RD_OUT <= RD_VALUE;
            end
        end
    end

`ifdef DECODER_6B5B_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;

    always_ff @(posedge SBYTECLK or negedge RESET_N) begin
        if (!RESET_N)
            err_cnt <= '0;
        else if (s1_valid && (!dec_hit || disp_err_c) && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
    end

    assign ERR_CNT = err_cnt;
`else
    assign ERR_CNT = '0;
`endif

endmodule
